// File: rtl/pbus_pkg.sv
// Shared PBus definitions: request encodings, master state encoding and address map.
package pbus_pkg;

    localparam logic [1:0] PBUS_REQ_IDLE = 2'b00;
    localparam logic [1:0] PBUS_REQ_WR   = 2'b01;
    localparam logic [1:0] PBUS_REQ_RD   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GNT1 = 2'd2,
        ST_WAIT = 2'd3
    } pbm_state_t;

    // Halfword-address bases of the system map (address space 0)
    localparam logic [14:0] PBUS_IROM_BASE = 15'h0000;
    localparam logic [14:0] PBUS_IO_BASE   = 15'h0400;
    localparam logic [14:0] PBUS_KEYB_BASE = 15'h0500;
    localparam logic [14:0] PBUS_MONI_BASE = 15'h0600;
    localparam logic [14:0] PBUS_IRAM_BASE = 15'h0800;
    localparam logic [14:0] PBUS_EROM_BASE = 15'h1000;
    localparam logic [14:0] PBUS_ERAM_BASE = 15'h2000;

endpackage

// File: rtl/pbus_watchdog.sv
// Transaction watchdog: counts enabled cycles and flags the cycle whose edge
// would make the count reach TIMEOUT_CYCLES. TIMEOUT_CYCLES = 0 disables it.
module pbus_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 11
) (
    input  logic clk,
    input  logic rst_l,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && enable && (cnt == LIMIT);

endmodule

// File: rtl/pbus_master.sv
// CPU-side PBus initiator: one outstanding load/store, grant/ready tracking,
// single-cycle response pulse and watchdog abort.
module pbus_master
    import pbus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned TO_W           = 11
) (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [14:0] req_addr,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    input  logic        req_aspace,
    output logic        resp_valid,
    output logic [15:0] resp_rdata,
    output logic        resp_err,
    output logic [1:0]  PBusReq,
    output logic [14:0] PBusAddr,
    output logic [1:0]  PBusBE,
    output logic        PBusASpace,
    output logic [15:0] PBusDataOut,
    input  logic [15:0] PBusDataIn,
    input  logic        PBusGnt,
    input  logic        PBusRdy
);

    pbm_state_t  state_q, state_d;
    logic        accept, bad_be, done, abort, wd_expire;
    logic [15:0] wdata_q;

    assign req_ready   = (state_q == ST_IDLE);
    assign accept      = req_valid && req_ready;
    assign bad_be      = (req_be == 2'b00);
    assign PBusDataOut = (PBusReq == PBUS_REQ_WR) ? wdata_q : '0;

    pbus_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TO_W          (TO_W)
    ) u_watchdog (
        .clk   (clk),
        .rst_l (rst_l),
        .clear (accept),
        .enable(state_q != ST_IDLE),
        .expire(wd_expire)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Watchdog abort is tested before grant/ready so it wins a same-cycle completion
    always_comb begin
        state_d = state_q;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (bad_be) abort = 1'b1;
                    else        state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (wd_expire) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else if (PBusGnt) begin
                    state_d = ST_GNT1;
                end
            end
            ST_GNT1: begin
                if (wd_expire || !PBusGnt) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wd_expire || !PBusGnt) begin
                    abort   = 1'b1;
                    state_d = ST_IDLE;
                end else if (PBusRdy) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            PBusReq    <= PBUS_REQ_IDLE;
            PBusAddr   <= '0;
            PBusBE     <= '0;
            PBusASpace <= 1'b0;
            wdata_q    <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= done || abort;
            resp_err   <= abort;
            if (accept && !bad_be) begin
                PBusReq    <= req_write ? PBUS_REQ_WR : PBUS_REQ_RD;
                PBusAddr   <= req_addr;
                PBusBE     <= req_be;
                PBusASpace <= req_aspace;
                wdata_q    <= req_wdata;
            end else if (done || abort) begin
                PBusReq <= PBUS_REQ_IDLE;
            end
            if (done && PBusReq[1]) begin
                resp_rdata <= PBusDataIn;
            end
        end
    end

endmodule

// File: tb/tb_pbus_master.sv
// Scoreboard bench for pbus_master: directed vectors with a modelled arbiter.
module tb_pbus_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_l;
    logic        req_valid, req_write, req_aspace, req_ready;
    logic [14:0] req_addr;
    logic [1:0]  req_be;
    logic [15:0] req_wdata;
    logic        resp_valid, resp_err;
    logic [15:0] resp_rdata;
    logic [1:0]  PBusReq, PBusBE;
    logic [14:0] PBusAddr;
    logic        PBusASpace, PBusGnt, PBusRdy;
    logic [15:0] PBusDataOut, PBusDataIn;

    logic        wd_valid, wd_ready, wd_resp_valid, wd_resp_err, wd_aspace, wd_gnt, wd_rdy;
    logic [15:0] wd_rdata, wd_dout, wd_din;
    logic [1:0]  wd_req, wd_be;
    logic [14:0] wd_addr;

    pbus_master u_dut (
        .clk(clk), .rst_l(rst_l),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_aspace(req_aspace),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .PBusReq(PBusReq), .PBusAddr(PBusAddr), .PBusBE(PBusBE), .PBusASpace(PBusASpace),
        .PBusDataOut(PBusDataOut), .PBusDataIn(PBusDataIn), .PBusGnt(PBusGnt), .PBusRdy(PBusRdy)
    );

    pbus_master #(.TIMEOUT_CYCLES(8), .TO_W(4)) u_wd (
        .clk(clk), .rst_l(rst_l),
        .req_valid(wd_valid), .req_ready(wd_ready), .req_write(req_write),
        .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_aspace(req_aspace),
        .resp_valid(wd_resp_valid), .resp_rdata(wd_rdata), .resp_err(wd_resp_err),
        .PBusReq(wd_req), .PBusAddr(wd_addr), .PBusBE(wd_be), .PBusASpace(wd_aspace),
        .PBusDataOut(wd_dout), .PBusDataIn(wd_din), .PBusGnt(wd_gnt), .PBusRdy(wd_rdy)
    );

    typedef struct {
        logic        err;
        logic [15:0] rdata;
        int          cyc;
    } exp_t;

    exp_t q[$];
    exp_t wq[$];
    exp_t mon_e;
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   age = 0;
    int   rdy_age = 3;
    int   gnt_drop = 1000;
    bit   rdy_stuck = 1'b0;
    int   a1, a2;
    bit   seen;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Arbiter model: Gnt one cycle after Req is seen, then Rdy from age rdy_age
    initial begin
        PBusGnt = 1'b0;
        PBusRdy = 1'b0;
        forever begin
            @(negedge clk);
            age     = PBusReq[0] ? age + 1 : 0;
            PBusGnt = (age >= 2) && (age < gnt_drop);
            PBusRdy = rdy_stuck || (PBusGnt && (age >= rdy_age));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (resp_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    $display("FAIL resp_unexpected: resp_valid=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("resp_cycle", cyc, mon_e.cyc);
                    chk("resp_err", resp_err, mon_e.err);
                    chk("resp_rdata", resp_rdata, mon_e.rdata);
                end
            end
            if (wd_resp_valid) begin
                if (wq.size() == 0) begin
                    checks++;
                    $display("FAIL wd_resp_unexpected: resp_valid=1, expected 0 (cycle %0d)", cyc);
                end else begin
                    mon_e = wq.pop_front();
                    chk("wd_resp_cycle", cyc, mon_e.cyc);
                    chk("wd_resp_err", wd_resp_err, mon_e.err);
                    chk("wd_resp_rdata", wd_rdata, mon_e.rdata);
                end
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input bit wd, input logic wr, input logic [14:0] addr,
                         input logic [1:0] be, input logic [15:0] wdata, input bit rsp,
                         input int lat, input logic err, input logic [15:0] rdata,
                         output int acc);
        exp_t e;
        req_write = wr;
        req_addr  = addr;
        req_be    = be;
        req_wdata = wdata;
        req_aspace = 1'b0;
        if (wd) wd_valid = 1'b1;
        else    req_valid = 1'b1;
        acc = -1;
        for (int i = 0; i < 50 && acc < 0; i++) begin
            if (wd ? wd_ready : req_ready) acc = cyc + 1;
            else @(negedge clk);
        end
        if (acc < 0) begin
            checks++;
            $display("FAIL accept_timeout: req_ready=0 for 50 cycles, expected 1");
        end else begin
            e.err = err;
            e.rdata = rdata;
            e.cyc = acc + lat;
            if (rsp) begin
                if (wd) wq.push_back(e);
                else    q.push_back(e);
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        wd_valid  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_timeout: simulation still running, expected completion");
        $fatal(1);
    end

    initial begin
        rst_l = 1'b0;
        req_valid = 1'b0; wd_valid = 1'b0;
        req_write = 1'b0; req_addr = '0; req_be = '0; req_wdata = '0; req_aspace = 1'b0;
        PBusDataIn = '0; wd_din = '0; wd_gnt = 1'b0; wd_rdy = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_pbus_req", PBusReq, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_dataout", PBusDataOut, 0);
        rst_l = 1'b1;
        @(negedge clk);

        // 1: read with Rdy stuck high; the dead cycle must not complete early
        rdy_stuck = 1'b1;
        PBusDataIn = 16'hBEEF;
        issue(0, 1'b0, 15'h0400, 2'b11, 16'h0000, 1, 4, 1'b0, 16'hBEEF, a1);
        chk("t1_req", PBusReq, 2'b11);
        chk("t1_addr", PBusAddr, 15'h0400);
        repeat (4) @(negedge clk);
        chk("t1_req_drop", PBusReq, 0);
        rdy_stuck = 1'b0;

        // 2: write stalled six WAIT cycles; rdata must keep the previous load value
        PBusDataIn = 16'h1111;
        rdy_age = 10;
        issue(0, 1'b1, 15'h0801, 2'b01, 16'h00A5, 1, 10, 1'b0, 16'hBEEF, a1);
        chk("t2_req", PBusReq, 2'b01);
        chk("t2_dout", PBusDataOut, 16'h00A5);
        chk("t2_be", PBusBE, 2'b01);
        repeat (6) @(negedge clk);
        chk("t2_dout_held", PBusDataOut, 16'h00A5);
        repeat (4) @(negedge clk);
        chk("t2_dout_idle", PBusDataOut, 0);
        rdy_age = 3;

        // 3: back-to-back read then write
        PBusDataIn = 16'h5A5A;
        issue(0, 1'b0, 15'h0123, 2'b10, 16'h0000, 1, 4, 1'b0, 16'h5A5A, a1);
        repeat (4) @(negedge clk);
        chk("t3_gap_req", PBusReq[0], 0);
        issue(0, 1'b1, 15'h0124, 2'b11, 16'hC3C3, 1, 4, 1'b0, 16'h5A5A, a2);
        chk("t3_spacing", a2 - a1, 5);
        repeat (4) @(negedge clk);

        // 4: watchdog on the TIMEOUT_CYCLES=8 instance
        wd_din = 16'h1234;
        issue(1, 1'b0, 15'h0200, 2'b11, 16'h0000, 1, 3, 1'b0, 16'h1234, a1);
        wd_gnt = 1'b1; wd_rdy = 1'b1;
        repeat (3) @(negedge clk);
        wd_gnt = 1'b0; wd_rdy = 1'b0;
        wd_din = 16'hDEAD;
        issue(1, 1'b0, 15'h0201, 2'b11, 16'h0000, 1, 8, 1'b1, 16'h1234, a1);
        repeat (7) @(negedge clk);
        chk("t4_req_held", wd_req[0], 1);
        @(negedge clk);
        chk("t4_req_drop", wd_req, 0);
        issue(1, 1'b1, 15'h0202, 2'b01, 16'h0055, 1, 3, 1'b0, 16'h1234, a1);
        wd_gnt = 1'b1; wd_rdy = 1'b1;
        repeat (3) @(negedge clk);
        wd_gnt = 1'b0; wd_rdy = 1'b0;

        // 5a: grant withdrawn while waiting for ready
        gnt_drop = 5;
        rdy_age = 100;
        issue(0, 1'b0, 15'h0300, 2'b11, 16'h0000, 1, 5, 1'b1, 16'h5A5A, a1);
        repeat (5) @(negedge clk);
        chk("t5_gnt_loss_req", PBusReq, 0);
        gnt_drop = 1000;

        // 5b: asynchronous reset in WAIT, no response afterwards
        issue(0, 1'b0, 15'h0301, 2'b11, 16'h0000, 0, 0, 1'b0, 16'h0000, a1);
        repeat (4) @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        chk("t5_async_req", PBusReq, 0);
        chk("t5_async_ready", req_ready, 1);
        @(negedge clk);
        rst_l = 1'b1;
        rdy_age = 3;
        repeat (6) @(negedge clk);

        // 6: illegal byte enables never reach the bus
        issue(0, 1'b0, 15'h0400, 2'b00, 16'h0000, 1, 0, 1'b1, 16'h0000, a1);
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (PBusReq != 2'b00) seen = 1'b1;
            @(negedge clk);
        end
        chk("t6_no_req", seen, 0);

        chk("q_drained", q.size(), 0);
        chk("wq_drained", wq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
